// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus arbiter: transaction phase encoding
// and the width of the binary owner index.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CTRL  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } phase_t;

    localparam int MASTERS_MAX = 8;
    localparam int IDX_W       = 3;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester strictly after rr_ptr,
// wrapping modulo MASTERS, so the previous winner has the lowest priority.
module bus_arbiter_rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int MASTERS = 4
) (
    input  logic [MASTERS-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic found_s;
    logic hit_s;

    // Two ascending scans: indices above the pointer first, then the wrapped part.
    always_comb begin
        winner  = {IDX_W{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            hit_s   = !found_s && req[i] && (i > int'(rr_ptr));
            winner  = hit_s ? IDX_W'(i) : winner;
            found_s = found_s | hit_s;
        end
        for (int i = 0; i < MASTERS; i++) begin
            hit_s   = !found_s && req[i] && (i <= int'(rr_ptr));
            winner  = hit_s ? IDX_W'(i) : winner;
            found_s = found_s | hit_s;
        end
        valid = |req;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Bus arbiter: grants one master per transaction and sequences it as
// CTRL/READ/WRITE strobes, with round-robin fairness and bounded locking.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MASTERS  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MASTERS-1:0] req,
    input  logic [MASTERS-1:0] lock,
    output logic [MASTERS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               ctrl_strobe,
    output logic               read_strobe,
    output logic               write_strobe,
    output logic [MASTERS-1:0] done,
    output logic               busy
);

    localparam int              HC_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX - 1);

    phase_t             state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [HC_W-1:0]    hold_cnt_r;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_valid_s;
    logic [MASTERS-1:0] win_oh_s;
    logic               keep_s;

    bus_arbiter_rr_picker #(
        .MASTERS (MASTERS)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .winner (win_idx_s),
        .valid  (win_valid_s)
    );

    assign win_oh_s = {{(MASTERS-1){1'b0}}, 1'b1} << win_idx_s;
    // grant is one-hot, so this masks req/lock down to the current owner only
    assign keep_s   = (|(req & lock & grant)) && (hold_cnt_r < HOLD_LIM);

    // Phase FSM with all bus-facing outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= IDX_W'(MASTERS - 1);
            hold_cnt_r   <= {HC_W{1'b0}};
            grant        <= {MASTERS{1'b0}};
            grant_idx    <= {IDX_W{1'b0}};
            ctrl_strobe  <= 1'b0;
            read_strobe  <= 1'b0;
            write_strobe <= 1'b0;
            done         <= {MASTERS{1'b0}};
            busy         <= 1'b0;
        end else begin
            ctrl_strobe  <= 1'b0;
            read_strobe  <= 1'b0;
            write_strobe <= 1'b0;
            done         <= {MASTERS{1'b0}};
            case (state_r)
                ST_CTRL: begin
                    state_r     <= ST_READ;
                    read_strobe <= 1'b1;
                    busy        <= 1'b1;
                end
                ST_READ: begin
                    state_r      <= ST_WRITE;
                    write_strobe <= 1'b1;
                    done         <= grant;
                    busy         <= 1'b1;
                end
                ST_IDLE, ST_WRITE: begin
                    if ((state_r == ST_WRITE) && keep_s) begin
                        state_r     <= ST_CTRL;
                        hold_cnt_r  <= hold_cnt_r + HC_W'(1);
                        ctrl_strobe <= 1'b1;
                        busy        <= 1'b1;
                    end else if (win_valid_s) begin
                        state_r     <= ST_CTRL;
                        grant       <= win_oh_s;
                        grant_idx   <= win_idx_s;
                        rr_ptr_r    <= win_idx_s;
                        hold_cnt_r  <= {HC_W{1'b0}};
                        ctrl_strobe <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        grant      <= {MASTERS{1'b0}};
                        grant_idx  <= {IDX_W{1'b0}};
                        hold_cnt_r <= {HC_W{1'b0}};
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant      <= {MASTERS{1'b0}};
                    grant_idx  <= {IDX_W{1'b0}};
                    hold_cnt_r <= {HC_W{1'b0}};
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter; granted owners are queued when
// requests are driven and popped by a monitor as each CTRL phase appears.
module tb_bus_arbiter;

    localparam int M     = 4;
    localparam int H     = 8;
    localparam int BOUND = (M - 1) * H;

    logic         clk = 1'b0;
    logic         reset;
    logic [M-1:0] req, lock, grant, done;
    logic [2:0]   grant_idx;
    logic         ctrl_strobe, read_strobe, write_strobe, busy;

    int           nvec = 0;
    int           nmis = 0;
    int           exp_q[$];
    bit           sb_en = 1'b0;
    bit           rand_en = 1'b0;
    int           waits[M];
    logic [M-1:0] req_q;

    bus_arbiter #(.MASTERS(M), .HOLD_MAX(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .lock         (lock),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .ctrl_strobe  (ctrl_strobe),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check(tag, {17'd0, grant, grant_idx, ctrl_strobe, read_strobe, write_strobe, done, busy}, 32'd0);
    endtask

    task automatic do_reset();
        req   = '0;
        lock  = '0;
        reset = 1'b0;
        #1;
        check_idle("reset_outputs");
        tick();
        check_idle("reset_hold");
        exp_q.delete();
        reset = 1'b1;
    endtask

    // One full transaction of master idx: queue it, then check C, R, W phases.
    task automatic expect_xact(input int idx);
        exp_q.push_back(idx);
        tick();
        check("ctrl_phase", {29'd0, ctrl_strobe, read_strobe, write_strobe}, 32'd4);
        check("ctrl_idx", {29'd0, grant_idx}, idx);
        check("ctrl_grant", {28'd0, grant}, 32'd1 << idx);
        tick();
        check("read_phase", {29'd0, ctrl_strobe, read_strobe, write_strobe}, 32'd2);
        check("read_idx", {29'd0, grant_idx}, idx);
        tick();
        check("write_phase", {29'd0, ctrl_strobe, read_strobe, write_strobe}, 32'd1);
        check("write_done", {28'd0, done}, 32'd1 << idx);
    endtask

    always @(posedge clk) req_q <= req;

    // Per-cycle invariants, scoreboard pop at each CTRL, and starvation tracking.
    always @(negedge clk) begin
        if (reset) begin
            check("strobe_onehot0", {31'd0, $countones({ctrl_strobe, read_strobe, write_strobe}) <= 1}, 32'd1);
            if (write_strobe)
                check("done_owner", {28'd0, done}, {28'd0, grant});
            else
                check("done_quiet", {28'd0, done}, 32'd0);
            if (ctrl_strobe) begin
                check("grant_onehot", {28'd0, grant}, 32'd1 << grant_idx);
                if (sb_en) begin
                    if (exp_q.size() == 0)
                        check("sb_unexpected_grant", exp_q.size(), 32'd1);
                    else
                        check("sb_grant_idx", {29'd0, grant_idx}, exp_q.pop_front());
                end
            end
            if (rand_en) begin
                for (int i = 0; i < M; i++) begin
                    if (!req_q[i]) begin
                        waits[i] = 0;
                    end else if (ctrl_strobe) begin
                        if (grant_idx == 3'(i)) begin
                            waits[i] = 0;
                        end else begin
                            waits[i]++;
                            check("starvation", {31'd0, waits[i] <= BOUND}, 32'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        for (int i = 0; i < M; i++) waits[i] = 0;
        sb_en = 1'b1;

        // Test 1: reset asserted during READ aborts the transaction at once
        do_reset();
        req = 4'b0001;
        exp_q.push_back(0);
        tick();
        check("t1_ctrl", {31'd0, ctrl_strobe}, 32'd1);
        tick();
        check("t1_read", {31'd0, read_strobe}, 32'd1);
        req   = '0;
        reset = 1'b0;
        #1;
        check_idle("t1_abort");
        tick();
        check_idle("t1_abort_no_done");
        reset = 1'b1;
        req   = 4'b0001;
        expect_xact(0);
        req = '0;
        tick();
        check_idle("t1_back_idle");

        // Test 2: single requester, three back-to-back transactions
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 3; k++) expect_xact(2);
        req = '0;
        tick();
        check_idle("t2_idle");

        // Test 3: all masters request, grants rotate 0,1,2,3,0,1
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 6; k++) expect_xact(k % M);
        req = '0;
        tick();
        check_idle("t3_idle");

        // Test 4: master 0 locks, capped at HOLD_MAX transactions
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < H; k++) expect_xact(0);
        expect_xact(1);
        expect_xact(0);
        req  = '0;
        lock = '0;
        tick();
        check_idle("t4_idle");

        // Test 5: a request pulse outside WRITE is ignored, inside WRITE it wins
        do_reset();
        req = 4'b0001;
        exp_q.push_back(0);
        tick();
        check("t5_ctrl_idx", {29'd0, grant_idx}, 32'd0);
        req = 4'b0010;
        tick();
        check("t5_read", {31'd0, read_strobe}, 32'd1);
        req = '0;
        tick();
        check("t5_done0", {28'd0, done}, 32'd1);
        tick();
        check_idle("t5_pulse_ignored");
        req = 4'b0001;
        exp_q.push_back(0);
        tick();
        req = '0;
        tick();
        tick();
        check("t5_write", {31'd0, write_strobe}, 32'd1);
        req = 4'b0010;
        exp_q.push_back(1);
        tick();
        check("t5_grant1_idx", {29'd0, grant_idx}, 32'd1);
        check("t5_grant1_ctrl", {31'd0, ctrl_strobe}, 32'd1);
        req = '0;
        tick();
        tick();
        check("t5_done1", {28'd0, done}, 32'd2);
        tick();
        check_idle("t5_idle");
        check("sb_drained", exp_q.size(), 32'd0);

        // Test 6: random sticky requests and random lock
        do_reset();
        sb_en   = 1'b0;
        rand_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < M; i++) begin
                if (req[i] && ctrl_strobe && (grant_idx == 3'(i)))
                    req[i] = ($urandom_range(0, 1) == 1);
                else if (!req[i])
                    req[i] = ($urandom_range(0, 3) == 0);
            end
            lock = 4'($urandom_range(0, 15));
            tick();
        end
        req  = '0;
        lock = '0;
        for (int c = 0; c < 6; c++) tick();
        rand_en = 1'b0;
        check("t6_drain_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
